// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: default word format, gain pre-scale, FSM encoding
// and the arctangent table generator used by the rotation/vectoring cores.
package cordic_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int FRAC_DEF   = 30;
    localparam int GUARD_DEF  = 2;

    // 1/K for an infinite-iteration CORDIC, scaled by 2^30.
    localparam logic [31:0] K_INIT = 32'h26DD3B6B;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ROTATE = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // round(atan(2^-i) * 2^32); beyond i=10 the cubic term is below half an LSB.
    function automatic logic [63:0] atan_q32(input int i);
        case (i)
            0:       atan_q32 = 64'hC90F_DAA2;
            1:       atan_q32 = 64'h76B1_9C16;
            2:       atan_q32 = 64'h3EB6_EBF2;
            3:       atan_q32 = 64'h1FD5_BA9B;
            4:       atan_q32 = 64'h0FFA_ADDC;
            5:       atan_q32 = 64'h07FF_5556;
            6:       atan_q32 = 64'h03FF_EAAB;
            7:       atan_q32 = 64'h01FF_FD55;
            8:       atan_q32 = 64'h00FF_FFAB;
            9:       atan_q32 = 64'h007F_FFF5;
            10:      atan_q32 = 64'h003F_FFFF;
            default: atan_q32 = (i >= 0 && i < 32) ? (64'd1 << (32 - i)) : 64'd0;
        endcase
    endfunction

    // Rescale the 2^32 table to fbits fractional bits, rounding half-up.
    function automatic logic [63:0] atan_scaled(input int i, input int fbits);
        logic [63:0] t;
        t = atan_q32(i);
        if (fbits >= 32)
            return t << (fbits - 32);
        return (t + (64'd1 << (31 - fbits))) >> (32 - fbits);
    endfunction

    function automatic logic [63:0] atan_val(input int i);
        return atan_scaled(i, FRAC_DEF + GUARD_DEF);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Constant arctangent lookup: entry i is round(atan(2^-i) * 2^(FRAC+GUARD)).
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int FRAC  = 30,
    parameter int GUARD = 2,
    localparam int IDX_W  = $clog2(ITER),
    localparam int ATAN_W = FRAC + GUARD + 1
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [ATAN_W-1:0] atan
);

    logic [ATAN_W-1:0] tab [ITER];

    genvar gi;
    generate
        for (gi = 0; gi < ITER; gi++) begin : g_tab
            assign tab[gi] = ATAN_W'(atan_scaled(gi, FRAC + GUARD));
        end
    endgenerate

    assign atan = tab[idx];

endmodule

// File: rtl/cordic_cos_core.sv
// Iterative rotation-mode CORDIC: accepts one angle, performs ITER
// micro-rotations (one per clock) and presents rounded cos/sin until taken.
module cordic_cos_core
    import cordic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ITER   = 16,
    parameter int GUARD  = GUARD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] theta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] cos_out,
    output logic [DATA_W-1:0] sin_out,
    output logic              range_err
);

    localparam int WI     = DATA_W + GUARD + 1;
    localparam int IDX_W  = $clog2(ITER);
    localparam int ATAN_W = FRAC + GUARD + 1;

    localparam logic signed [DATA_W:0] ONE_E   = {{(DATA_W-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [WI-1:0]   SAT_MAX = {{(GUARD+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [WI-1:0]   SAT_MIN = {{(GUARD+2){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [WI-1:0]   HALF_G  = {{(WI-GUARD){1'b0}}, 1'b1, {(GUARD-1){1'b0}}};

    logic [1:0]              state_reg;
    logic signed [WI-1:0]    x_reg, y_reg, z_reg;
    logic [IDX_W-1:0]        i_reg;
    logic [DATA_W-1:0]       cos_reg, sin_reg;
    logic                    range_err_reg;

    logic [ATAN_W-1:0]       atan_w;
    logic signed [WI-1:0]    atan_ext, x_shr, y_shr;
    logic signed [WI-1:0]    x_next, y_next, z_next;
    logic signed [DATA_W:0]  theta_ext;
    logic                    range_next;

    // Drop the guard bits with half-up rounding and clamp to the output word.
    function automatic logic [DATA_W-1:0] round_sat(input logic signed [WI-1:0] v);
        logic signed [WI-1:0] r;
        r = (v + HALF_G) >>> GUARD;
        if (r > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (r < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        return r[DATA_W-1:0];
    endfunction

    cordic_atan_rom #(
        .ITER  (ITER),
        .FRAC  (FRAC),
        .GUARD (GUARD)
    ) u_atan_rom (
        .idx  (i_reg),
        .atan (atan_w)
    );

    always_comb begin
        atan_ext   = $signed({{(WI-ATAN_W){1'b0}}, atan_w});
        x_shr      = x_reg >>> i_reg;
        y_shr      = y_reg >>> i_reg;
        theta_ext  = $signed({theta[DATA_W-1], theta});
        range_next = (theta_ext > ONE_E) || (theta_ext < -ONE_E);
        // Rotate towards z = 0: negative residual means rotate clockwise.
        if (z_reg[WI-1]) begin
            x_next = x_reg + y_shr;
            y_next = y_reg - x_shr;
            z_next = z_reg + atan_ext;
        end else begin
            x_next = x_reg - y_shr;
            y_next = y_reg + x_shr;
            z_next = z_reg - atan_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            x_reg         <= '0;
            y_reg         <= '0;
            z_reg         <= '0;
            i_reg         <= '0;
            cos_reg       <= '0;
            sin_reg       <= '0;
            range_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg         <= {1'b0, DATA_W'(K_INIT), {GUARD{1'b0}}};
                        y_reg         <= '0;
                        z_reg         <= {theta[DATA_W-1], theta, {GUARD{1'b0}}};
                        i_reg         <= '0;
                        range_err_reg <= range_next;
                        state_reg     <= ROTATE;
                    end
                end
                ROTATE: begin
                    x_reg <= x_next;
                    y_reg <= y_next;
                    z_reg <= z_next;
                    i_reg <= i_reg + 1'b1;
                    if (i_reg == IDX_W'(ITER - 1)) begin
                        cos_reg   <= round_sat(x_next);
                        sin_reg   <= round_sat(y_next);
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign cos_out   = cos_reg;
    assign sin_out   = sin_reg;
    assign range_err = range_err_reg;

endmodule

// File: tb/tb_cordic_cos_core.sv
// Directed bench for cordic_cos_core: hand-computed cos/sin vectors, latency,
// backpressure, range flag, input blocking during rotation and mid-run reset.
module tb_cordic_cos_core;

    localparam int     DATA_W = 32;
    localparam int     FRAC   = 30;
    localparam int     ITER   = 16;
    localparam int     GUARD  = 2;
    localparam longint TOL    = 65536;        // 2^(FRAC-ITER+2)

    // Expected results, hand-computed as round(f(theta) * 2^30).
    localparam longint ONE_V   = 1073741824;  // 1.0
    localparam longint COS1    = 580145183;   // cos(1.0)   = 0.5403023
    localparam longint SIN1    = 903522590;   // sin(1.0)   = 0.8414710
    localparam longint COS05   = 942297101;   // cos(0.5)   = 0.8775826
    localparam longint SIN05   = 514779252;   // sin(0.5)   = 0.4794255
    localparam longint COS1125 = 462972359;   // cos(1.125) = 0.4311766
    localparam longint SIN1125 = 968802566;   // sin(1.125) = 0.9022677

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] theta = '0;
    logic              in_ready, out_valid, range_err;
    logic [DATA_W-1:0] cos_out, sin_out;

    int n_checks = 0;
    int n_errors = 0;

    cordic_cos_core #(
        .DATA_W (DATA_W),
        .FRAC   (FRAC),
        .ITER   (ITER),
        .GUARD  (GUARD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .theta     (theta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        n_checks++;
        if ((got - exp > tol) || (exp - got > tol)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // One full transaction: accept, latency, results, optional backpressure, handshake.
    task automatic run_vec(input string tag, input logic [DATA_W-1:0] th, input longint ecos,
                           input longint esin, input longint eerr, input bit vals, input int hold);
        int                cnt;
        bit                stable;
        logic [DATA_W-1:0] c0, s0;
        @(negedge clk);
        cnt = 0;
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_rdy"}, longint'(in_ready), 1, 0);
        in_valid = 1'b1;
        theta    = th;
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, longint'(cnt), longint'(ITER), 0);
        if (vals) begin
            check({tag, "_cos"}, longint'($signed(cos_out)), ecos, TOL);
            check({tag, "_sin"}, longint'($signed(sin_out)), esin, TOL);
        end
        check({tag, "_err"}, longint'(range_err), eerr, 0);
        c0 = cos_out;
        s0 = sin_out;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!out_valid || in_ready || cos_out != c0 || sin_out != s0 || range_err != eerr[0])
                stable = 1'b0;
        end
        if (hold > 0)
            check({tag, "_hold"}, longint'(stable), 1, 0);
        out_ready = 1'b1;
        check({tag, "_busy"}, longint'(in_ready), 0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop"}, longint'(out_valid), 0, 0);
        check({tag, "_idle"}, longint'(in_ready), 1, 0);
        check({tag, "_keep"}, longint'(cos_out == c0 && sin_out == s0), 1, 0);
        $display("txn %-10s theta=%h cos=%0d sin=%0d err=%0b lat=%0d",
                 tag, th, $signed(c0), $signed(s0), range_err, cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                a0, a1, acc, res, seen;
        logic [DATA_W-1:0] rc0, rs0, rc1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready",  longint'(in_ready), 1, 0);
        check("rst_out_valid", longint'(out_valid), 0, 0);
        check("rst_cos",       longint'(cos_out), 0, 0);
        check("rst_sin",       longint'(sin_out), 0, 0);
        check("rst_range_err", longint'(range_err), 0, 0);

        run_vec("zero",      32'h0000_0000, ONE_V,   0,       0, 1'b1, 0);
        run_vec("pos1",      32'h4000_0000, COS1,    SIN1,    0, 1'b1, 0);
        run_vec("neg1",      32'hC000_0000, COS1,    -SIN1,   0, 1'b1, 0);
        run_vec("half_bp",   32'h2000_0000, COS05,   SIN05,   0, 1'b1, 20);
        run_vec("oor",       32'h4800_0000, COS1125, SIN1125, 1, 1'b1, 0);
        run_vec("just_over", 32'h4000_0001, COS1,    SIN1,    1, 1'b1, 0);
        run_vec("minint",    32'h8000_0000, 0,       0,       1, 1'b0, 0);

        // in_valid held through rotation with a changed theta; out_ready held high.
        a0 = 0; a1 = 0; acc = 0; res = 0;
        rc0 = '0; rs0 = '0; rc1 = '0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        theta     = 32'h4000_0000;
        for (int c = 0; c < 200 && res < 2; c++) begin
            if (in_ready && in_valid) begin
                if (acc == 0) a0 = c;
                else          a1 = c;
                acc++;
            end
            if (out_valid) begin
                if (res == 0) begin
                    rc0 = cos_out;
                    rs0 = sin_out;
                end else begin
                    rc1 = cos_out;
                end
                res++;
            end
            if (acc == 1 && c == a0 + 3)
                check("tp_busy", longint'(in_ready), 0, 0);
            @(negedge clk);
            if (acc == 1) theta = 32'h2000_0000;
            if (acc >= 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("tp_results", longint'(res), 2, 0);
        check("tp_gap",     longint'(a1 - a0), longint'(ITER + 2), 0);
        check("tp_cos1",    longint'($signed(rc0)), COS1, TOL);
        check("tp_sin1",    longint'($signed(rs0)), SIN1, TOL);
        check("tp_cos05",   longint'($signed(rc1)), COS05, TOL);
        $display("txn %-10s gap=%0d results=%0d", "throughput", a1 - a0, res);

        // Reset in the middle of rotation must abort without a stale result.
        @(negedge clk);
        in_valid = 1'b1;
        theta    = 32'h4000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", longint'(in_ready), 0, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", longint'(in_ready), 1, 0);
        check("mid_rst_valid", longint'(out_valid), 0, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (ITER + 4) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("mid_no_stale", longint'(seen), 0, 0);
        $display("txn %-10s stale_seen=%0d", "mid_reset", seen);
        run_vec("after_rst", 32'h0000_0000, ONE_V, 0, 0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
